// File: rtl/ad_capture.sv
// rtl/ad_capture.sv - serial ADC capture sequencer feeding an EEPROM byte writer
module ad_capture #(
    parameter int         CLK_DIV     = 4,
    parameter int         SAMPLE_BITS = 12,
    parameter logic [7:0] CS_ADDR     = 8'hA0,
    parameter logic [7:0] ADDR_MAX    = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_sample,
    input  logic                   an_data,
    input  logic                   wr_ack,
    output logic                   dclk,
    output logic                   ad_cs_n,
    output logic [SAMPLE_BITS-1:0] amp_data,
    output logic [7:0]             tran_data,
    output logic                   en_write,
    output logic [7:0]             input_data,
    output logic [7:0]             cs_addr,
    output logic [7:0]             rw_addr,
    output logic                   full
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CONV  = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam int EDGES = 2 * SAMPLE_BITS;
    localparam int EW    = $clog2(EDGES + 1);

    logic [2:0]             state;
    logic [7:0]             div_cnt;
    logic [EW-1:0]          edge_cnt;
    logic [SAMPLE_BITS-1:0] shift_reg;
    logic                   armed;

    assign cs_addr    = CS_ADDR;
    assign tran_data  = amp_data[SAMPLE_BITS-1 -: 8];
    assign input_data = tran_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dclk      <= 1'b0;
            ad_cs_n   <= 1'b1;
            en_write  <= 1'b0;
            amp_data  <= '0;
            rw_addr   <= 8'h00;
            full      <= 1'b0;
            div_cnt   <= 8'h00;
            edge_cnt  <= '0;
            shift_reg <= '0;
            armed     <= 1'b0;
        end else begin
            // One idle edge after reset release before a conversion may start
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    dclk     <= 1'b0;
                    ad_cs_n  <= 1'b1;
                    en_write <= 1'b0;
                    if (en_sample && armed) begin
                        state    <= CONV;
                        ad_cs_n  <= 1'b0;
                        div_cnt  <= 8'h00;
                        edge_cnt <= '0;
                    end
                end
                CONV: begin
                    if (div_cnt == 8'(CLK_DIV - 1)) begin
                        div_cnt <= 8'h00;
                        dclk    <= ~dclk;
                        if (!dclk)
                            shift_reg <= {shift_reg[SAMPLE_BITS-2:0], an_data};
                        // Last toggle is a falling edge, so dclk rests low in LATCH
                        if (edge_cnt == EW'(EDGES - 1)) begin
                            state    <= LATCH;
                            ad_cs_n  <= 1'b1;
                            edge_cnt <= '0;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'h01;
                    end
                end
                LATCH: begin
                    amp_data <= shift_reg;
                    en_write <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (wr_ack) begin
                        en_write <= 1'b0;
                        state    <= NEXT;
                    end
                end
                NEXT: begin
                    en_write <= 1'b0;
                    if (rw_addr == ADDR_MAX) begin
                        full  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rw_addr <= rw_addr + 8'h01;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    dclk     <= 1'b0;
                    ad_cs_n  <= 1'b1;
                    en_write <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
